// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter
//   Two-port round-robin front end for the single-port data-memory word array.
//   Port 0 is the M-stage load/store unit, port 1 the debug/loader port.
//   Only one access is in flight at a time:
//     - loads read the array in ACC and return registered data one cycle later;
//     - full-word stores write in ACC;
//     - partial stores read the old word in ACC and write the merged word in MRG.
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   pN_req/we/be/addr   per-port request (held until pN_gnt)
//   pN_wdata/pN_pc      store data, issuing PC (PC only used by the write log)
//   pN_gnt              acceptance pulse (combinational, IDLE only)
//   rvalid/rid/rdata    load response, one cycle pulse
//   err                 out-of-range pulse, owner on rid
//   ram_we/addr/wdata   array write port and address
//   ram_rdata           combinational array read data
//
// Build option
//   DM_WRITE_LOG_EN     when defined, every array write is printed with its PC.

module dm_port_arbiter #(
  parameter int DEPTH = 3072,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [3:0]    p0_be,
  input  logic [31:0]   p0_addr,
  input  logic [31:0]   p0_wdata,
  input  logic [31:0]   p0_pc,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [3:0]    p1_be,
  input  logic [31:0]   p1_addr,
  input  logic [31:0]   p1_wdata,
  input  logic [31:0]   p1_pc,
  output logic          p0_gnt,
  output logic          p1_gnt,
  output logic          rvalid,
  output logic          rid,
  output logic [31:0]   rdata,
  output logic          err,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_MRG} state_t;

  state_t      r_state;
  logic        r_last;     // port granted most recently
  logic        r_id;
  logic        r_we;
  logic [3:0]  r_be;
  logic [29:0] r_idx;      // full word index, upper bits feed the range check
  logic [31:0] r_wdata;
  logic [31:0] r_old;      // old word captured for read-modify-write
  logic [31:0] r_rdata;
  logic        r_rvalid;
  logic        r_err;
  logic        r_rid;

  logic        w_both;
  logic        w_win;
  logic        w_accept;
  logic        w_oor;
  logic        w_full;
  logic [31:0] w_merge;

  // Tie goes to the port not granted last; a lone requester always wins.
  assign w_both   = p0_req & p1_req;
  assign w_win    = w_both ? ~r_last : p1_req;
  assign w_accept = (r_state == S_IDLE) & (p0_req | p1_req);
  assign p0_gnt   = w_accept & ~w_win;
  assign p1_gnt   = w_accept &  w_win;

  assign w_oor  = (r_idx >= 30'(DEPTH));
  assign w_full = (r_be == 4'hF);

  // Lane merge; with be=4'hF this is simply the new word, so the same path
  // serves the full-word write in ACC and the merged write in MRG.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign w_merge[8*i +: 8] = r_be[i] ? r_wdata[8*i +: 8] : r_old[8*i +: 8];
  end

  // ram_we is decoded from the state register so an asynchronous reset
  // removes it immediately.
  assign ram_we    = ((r_state == S_ACC) & r_we & w_full & ~w_oor) |
                     (r_state == S_MRG);
  assign ram_addr  = r_idx[AW-1:0];
  assign ram_wdata = w_merge;

  assign rvalid = r_rvalid;
  assign err    = r_err;
  assign rid    = r_rid;
  assign rdata  = r_rdata;

`ifdef DM_WRITE_LOG_EN
  logic [31:0] r_pc;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_last   <= 1'b1;        // port 0 wins the first tie
      r_id     <= 1'b0;
      r_we     <= 1'b0;
      r_be     <= 4'h0;
      r_idx    <= '0;
      r_wdata  <= '0;
      r_old    <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rid    <= 1'b0;
`ifdef DM_WRITE_LOG_EN
      r_pc     <= '0;
`endif
    end else begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_id    <= w_win;
            r_last  <= w_win;
            r_we    <= w_win ? p1_we         : p0_we;
            r_be    <= w_win ? p1_be         : p0_be;
            r_idx   <= w_win ? p1_addr[31:2] : p0_addr[31:2];
            r_wdata <= w_win ? p1_wdata      : p0_wdata;
`ifdef DM_WRITE_LOG_EN
            r_pc    <= w_win ? p1_pc         : p0_pc;
`endif
            r_state <= S_ACC;
          end
        end
        S_ACC: begin
          r_state <= S_IDLE;
          if (w_oor) begin
            r_err <= 1'b1;
            r_rid <= r_id;
            if (!r_we) begin
              r_rvalid <= 1'b1;
              r_rdata  <= '0;
            end
          end else if (!r_we) begin
            r_rvalid <= 1'b1;
            r_rid    <= r_id;
            r_rdata  <= ram_rdata;
          end else if (!w_full && (r_be != 4'h0)) begin
            r_old   <= ram_rdata;
            r_state <= S_MRG;
          end
        end
        S_MRG:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Byte offset bits carry no information for a word array.
  wire w_unused_abits = ^{p0_addr[1:0], p1_addr[1:0]};

`ifdef DM_WRITE_LOG_EN
  always_ff @(posedge clk) begin
    if (reset && ram_we)
      $display("%d@%h: *%h <= %h", $time, r_pc, {r_idx, 2'b00}, ram_wdata);
  end
`else
  wire w_unused_pc = ^{p0_pc, p1_pc};
`endif

endmodule

// File: doc/dm_port_arbiter.md
# dm_port_arbiter

Arbitrates and sequences access to the single-port data-memory word array on behalf of two requesters: the M-stage load/store unit (port 0) and a debug/loader port (port 1). Requests are granted round-robin and executed one at a time. Full-word stores complete in one memory cycle; partial stores (byte/halfword enables) run a two-cycle read-modify-write. The block sits between the M stage and the DM array; the array keeps its combinational read and its synchronous write.

## Interface
- `DEPTH`, 3072: number of 32-bit words in the DM array.
- `AW`, 12: word-index width driven to the array (`ceil(log2(DEPTH))`).

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `p0_req`, `p1_req`  in  1  request valid; must be held stable until the matching `gnt`.
- `p0_we`, `p1_we`  in  1  1 = store, 0 = load.
- `p0_be`, `p1_be`  in  4  byte enables for stores; bit i covers `wdata[8i+7:8i]`; ignored for loads.
- `p0_addr`, `p1_addr`  in  32  byte address; bits [1:0] are ignored.
- `p0_wdata`, `p1_wdata`  in  32  store data, already lane-aligned.
- `p0_pc`, `p1_pc`  in  32  PC of the issuing instruction, used only for logging.
- `p0_gnt`, `p1_gnt`  out  1  one-cycle pulse: request accepted on this edge.
- `rvalid`  out  1  one-cycle pulse: `rdata` is valid for the most recent load.
- `rid`  out  1  port that owns the current `rvalid` or `err`.
- `rdata`  out  32  registered load data.
- `err`  out  1  one-cycle pulse: the accepted access was out of range.
- `ram_we`  out  1  array write enable.
- `ram_addr`  out  AW  array word index.
- `ram_wdata`  out  32  array write data.
- `ram_rdata`  in  32  combinational array read data at `ram_addr`.

## Operation
- **States.** IDLE, ACC, MRG.
- **Acceptance (IDLE).**
  - If any `req` is high, assert the winner's `gnt` combinationally.
  - Latch we/be/addr/wdata/pc and the port id into the command register.
  - Move to ACC.
  - Do not assert `gnt` in ACC or MRG.
- **Arbitration.**
  - Round-robin: on a tie, the port not granted last wins.
  - After reset, port 0 wins the first tie.
  - A lone requester always wins.
- **Range check.** A word index of `addr[31:2] >= DEPTH` is out of range.
  - ACC then performs no write and sets `err` with `rid` for the next cycle.
  - A load also sets `rvalid` with `rdata` = 0.
  - Next state is IDLE.
- **ACC, load.** Drive `ram_addr = addr[AW+1:2]`, register `ram_rdata` into `rdata`, set `rvalid` next cycle, return to IDLE.
- **ACC, store with `be` = 4'hF.** Assert `ram_we` with `ram_wdata = wdata`, return to IDLE.
- **ACC, store with `be` = 0.** No write, return to IDLE (no-op).
- **ACC, partial store.** Register `ram_rdata` as the old word, no write, go to MRG.
- **MRG.**
  - Assert `ram_we` at the same address.
  - Write data per byte lane: new byte where `be[i]` is set, old byte otherwise.
  - Return to IDLE.
- **Outputs outside ACC/MRG.** `ram_we` = 0 and `ram_addr` holds the last command's index.

## Timing
- **Reset values:** state IDLE, all `gnt`/`rvalid`/`err`/`ram_we` = 0, `rdata` = 0, `rid` = 0, `ram_addr` = 0, `ram_wdata` = 0, round-robin pointer favouring port 0.
- **Load:** `gnt` in cycle N, array read in N+1, `rvalid`/`rdata` in N+2.
- **Store:** the write edge ends N+1 (full word) or N+2 (partial).
- **Throughput:** the next `gnt` can come no earlier than N+2 (full word or load) or N+3 (RMW). IDLE accepts in the same cycle `rvalid` is high.
- **Simultaneous requests:** exactly one `gnt` per acceptance; the loser keeps `req` high and is granted at the next IDLE.
- **Reset asserted mid-operation:**
  - State goes to IDLE immediately and `ram_we` drops asynchronously.
  - A pending RMW write is discarded and no `rvalid` is produced.
  - Array contents are unaffected; clearing the array is the array's job.
- **Dropped request:** `req` falling before `gnt` withdraws the request without side effects. `req` must not fall in the cycle of its own `gnt`.

## Configuration
- **`DM_WRITE_LOG_EN` defined:**
  - Every edge with `ram_we` = 1 prints `"%d@%h: *%h <= %h"` with `$time`, the command's pc, the word-aligned byte address `{addr[31:2],2'b00}` and the final written word (merged word for RMW).
  - Nothing is printed for suppressed or out-of-range stores.
- **`DM_WRITE_LOG_EN` undefined:** no `$display` is compiled and the `pc` inputs are unused. Cycle behaviour is identical.

## Test plan
- **Load.** Preload word 5 = 32'hDEADBEEF; p0 loads addr 32'h14 → `gnt` cycle N, `rvalid` with `rdata` = 32'hDEADBEEF and `rid` = 0 in N+2.
- **Partial store (RMW).** Word 3 = 32'h11223344; p1 stores be = 4'b0101, wdata = 32'hAABBCCDD at 32'h0C → single `ram_we` at N+2, word 3 = 32'h11BB33DD. Log line shows `*0000000c <= 11bb33dd`.
- **Contention.** p0 and p1 request together from reset → p0 granted first, p1 next. Another simultaneous pair → p0 then p1 again, since p1 was granted last.
- **Out of range.** Store at 32'h00003000 (index 3072) → no `ram_we`, `err` pulse in N+2. A load at the same address → `rvalid` with `rdata` = 0.
- **Reset mid-RMW.** Assert `reset` low during MRG → `ram_we` drops in the same cycle, the word is unchanged, no `rvalid`/`err`. After release, p0 wins the first tie.
- **Full-word and no-op stores.** Full-word store be = 4'hF → exactly one `ram_we` at N+1. be = 0 → no `ram_we`, and the next `gnt` at N+2.
